// File: rtl/sigdelay_pkg.sv
// Shared types and arithmetic for the sigdelay echo delay line.
// Holds the fill/run state encoding and the saturating adder used by the feedback path.
package sigdelay_pkg;

  typedef enum logic {FILL, RUN} state_t;

  localparam int SAT_W = 32;
  localparam logic signed [SAT_W:0] SAT_ONE = {{SAT_W{1'b0}}, 1'b1};

  // Add two sign-extended samples and clamp the result to a signed field of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             width
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = (SAT_ONE <<< (width - 1)) - SAT_ONE;
    lo  = -(SAT_ONE <<< (width - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/sigdelay_echo_ram2ports.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// Read data appears one clock after rd_en; no backpressure, contents are never reset.
module ram2ports #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Old data is returned when reading an address written on the same edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sigdelay_echo.sv
// Circular-buffer delay line with runtime delay and optional comb feedback echo.
// Two-cycle latency from in_valid to out_valid; no backpressure, gaps in in_valid stall all state.
module sigdelay_echo
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int S_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [D_WIDTH-1:0] in_data,
  input  logic        [A_WIDTH-1:0] delay,
  input  logic                      fb_en,
  input  logic        [S_WIDTH-1:0] fb_shift,
  output logic                      out_valid,
  output logic signed [D_WIDTH-1:0] out_data,
  output logic                      primed
);

  state_t state, state_nxt;
  logic [A_WIDTH-1:0] wr_ptr, fill_cnt, fill_nxt, delay_q, delay_nxt, rd_addr;
  logic rd_en, fwd_hit;
  logic s1_vld, s1_primed, s1_bypass, s1_fwd;
  logic [A_WIDTH-1:0] s1_ptr;
  logic signed [D_WIDTH-1:0] s1_x, s1_fwd_dat, ram_q, d, e, w, y;

  // A delay change is visible on primed in the same cycle, before delay_q catches up.
  assign primed  = (state == RUN) && (delay == delay_q);
  assign rd_addr = wr_ptr - delay;
  assign rd_en   = in_valid && (delay != '0);
  assign fwd_hit = in_valid && s1_vld && (rd_addr == s1_ptr);

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    delay_nxt = delay_q;
    if (delay != delay_q) begin
      delay_nxt = delay;
      fill_nxt  = '0;
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            fill_nxt = fill_cnt + 1'b1;
          end
          if (fill_nxt >= delay_q) begin
            state_nxt = RUN;
          end
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      delay_q  <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      delay_q  <= delay_nxt;
      if (in_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    d = '0;
    if (s1_primed) begin
      d = s1_fwd ? s1_fwd_dat : ram_q;
    end
    e = d >>> fb_shift;
    w = s1_x;
    y = d;
    if (s1_bypass) begin
      y = s1_x;
    end else if (fb_en) begin
      w = D_WIDTH'(sat_add(SAT_W'(s1_x), SAT_W'(e), D_WIDTH));
      y = w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld     <= 1'b0;
      s1_x       <= '0;
      s1_ptr     <= '0;
      s1_primed  <= 1'b0;
      s1_bypass  <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_fwd_dat <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      s1_vld    <= in_valid;
      out_valid <= s1_vld;
      if (in_valid) begin
        s1_x       <= in_data;
        s1_ptr     <= wr_ptr;
        s1_primed  <= primed;
        s1_bypass  <= (delay == '0);
        s1_fwd     <= fwd_hit;
        s1_fwd_dat <= w;
      end
      if (s1_vld) begin
        out_data <= y;
      end
    end
  end

  ram2ports #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s1_vld),
    .wr_addr (s1_ptr),
    .wr_data (w),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_sigdelay_echo.sv
// Randomised scoreboard bench for sigdelay_echo against a sample-history reference model.
module tb_sigdelay_echo;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] delay = '0;
  logic          fb_en = 1'b0;
  logic [SW-1:0] fb_shift = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          primed;

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   hist[$];
  int   m_cnt = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sigdelay_echo #(.A_WIDTH(AW), .D_WIDTH(DW), .S_WIDTH(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .delay     (delay),
    .fb_en     (fb_en),
    .fb_shift  (fb_shift),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference: a sample is primed once 'delay' samples have arrived since the last
  // delay change; its delayed input is the value written 'delay' samples earlier.
  task automatic model_issue(input int x);
    int  n, dd, wv, yv, dl;
    bit  pr;
    n  = hist.size();
    dl = int'(delay);
    pr = (m_cnt >= dl);
    m_cnt++;
    if (dl == 0) begin
      wv = x;
      yv = x;
    end else begin
      dd = pr ? hist[n - dl] : 0;
      if (!fb_en) begin
        wv = x;
        yv = dd;
      end else begin
        wv = clamp8(x + (dd >>> fb_shift));
        yv = wv;
      end
    end
    hist.push_back(wv);
    sb.push_back('{yv, cyc});
  endtask

  task automatic step(input bit v, input int x);
    bit pe;
    pe       = (m_cnt >= int'(delay));
    in_valid = v;
    in_data  = DW'(x);
    if (v) model_issue(x);
    #1;
    if (delay != '0) check("primed", int'(primed), int'(pe));
    @(negedge clk);
  endtask

  task automatic set_delay(input int dl);
    if (dl != int'(delay)) m_cnt = 0;
    delay = AW'(dl);
    step(1'b0, 0);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t ex;
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: out_valid=1 with out_data=%0d, expected no output", $signed(out_data));
      end else begin
        ex = sb.pop_front();
        check("out_data", int'($signed(out_data)), ex.y);
        check("latency", cyc - ex.cyc, 2);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_primed", int'(primed), 0);

    // Prime with delay 4 and a counting ramp
    delay = 4'd4;
    hist.delete(); sb.delete(); m_cnt = 0;
    rst = 1'b1;
    step(1'b0, 0);
    for (int k = 1; k <= 12; k++) step(1'b1, k);
    drain();

    // Maximum delay across the pointer wrap
    set_delay(15);
    for (int k = 0; k < 40; k++) step(1'b1, k * 3 - 60);
    drain();

    // delay 1 back-to-back: delayed sample comes from the forwarding path
    fb_en = 1'b1; fb_shift = 3'd1;
    set_delay(1);
    step(1'b1, 0);
    step(1'b1, 64);
    repeat (3) step(1'b1, 0);
    drain();

    // Saturation at both rails
    fb_shift = 3'd0;
    set_delay(2);
    repeat (10) step(1'b1, 100);
    repeat (12) step(1'b1, -100);
    drain();

    // Delay change in RUN with gapped input
    fb_en = 1'b0;
    set_delay(3);
    for (int k = 0; k < 6; k++) step(1'b1, k + 10);
    set_delay(5);
    for (int i = 0; i < 14; i++) step((i % 2) == 0, 20 + i);
    drain();

    // Randomised segments
    for (int seg = 0; seg < 6; seg++) begin
      fb_en    = 1'($urandom_range(0, 1));
      fb_shift = SW'($urandom_range(0, 7));
      set_delay(int'($urandom_range(0, 15)));
      for (int i = 0; i < 40; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) step(1'b1, int'($urandom_range(0, 255)) - 128);
        else if (r == 9) set_delay(int'($urandom_range(0, 15)));
        else step(1'b0, 0);
      end
      drain();
    end

    // Asynchronous reset between edges while output is active
    fb_en = 1'b0;
    set_delay(2);
    for (int i = 1; i <= 6; i++) step(1'b1, 7 * i);
    @(posedge clk);
    #2;
    check("out_valid_before_rst", int'(out_valid), 1);
    check("primed_before_rst", int'(primed), 1);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out_data", int'(out_data), 0);
    check("async_rst_primed", int'(primed), 0);
    sb.delete(); hist.delete(); m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, i - 4);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
